// File: rtl/reg_writeback_if.sv
// Bundle of ALU/load result inputs, register-file write outputs and bypass
// signals for reg_writeback. The slave modport is the writeback stage itself.
interface reg_writeback_if #(
    parameter int LD_DEPTH = 2
) ();
    localparam int CW = $clog2(LD_DEPTH) + 1;

    // Load port handshake: an entry transfers on a rising edge when
    // ld_valid_i && ld_ready_o; ld_ready_o never depends on ld_valid_i.
    logic          alu_valid_i;
    logic [4:0]    alu_rd_i;
    logic [31:0]   alu_data_i;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic [4:0]    ld_rd_i;
    logic [31:0]   ld_data_i;
    logic          we_o;
    logic [4:0]    ws_o;
    logic [31:0]   wd_o;
    logic [4:0]    rs1_i;
    logic [4:0]    rs2_i;
    logic          fwd1_valid_o;
    logic          fwd2_valid_o;
    logic [31:0]   fwd1_data_o;
    logic [31:0]   fwd2_data_o;
    logic [CW-1:0] ld_count_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_valid_i, ld_rd_i, ld_data_i,
        input  rs1_i, rs2_i,
        output ld_ready_o, we_o, ws_o, wd_o,
        output fwd1_valid_o, fwd2_valid_o, fwd1_data_o, fwd2_data_o,
        output ld_count_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_valid_i, ld_rd_i, ld_data_i,
        output rs1_i, rs2_i,
        input  ld_ready_o, we_o, ws_o, wd_o,
        input  fwd1_valid_o, fwd2_valid_o, fwd1_data_o, fwd2_data_o,
        input  ld_count_o
    );
endinterface

// File: rtl/reg_writeback.sv
// Single-port register writeback: ALU results take priority over a small
// load-result FIFO; write-same-edge reads are bypassed through fwdN outputs.
module reg_writeback #(
    parameter int LD_DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    reg_writeback_if.slave bus
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

    logic [4:0]    buf_rd_q   [LD_DEPTH];
    logic [31:0]   buf_data_q [LD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          we_q, we_d;
    logic [4:0]    ws_q, ws_d;
    logic [31:0]   wd_q, wd_d;
    logic          fwd1_valid_q, fwd1_valid_d;
    logic          fwd2_valid_q, fwd2_valid_d;
    logic [31:0]   fwd1_data_q, fwd1_data_d;
    logic [31:0]   fwd2_data_q, fwd2_data_d;

    logic          ld_ready;
    logic          push;
    logic          pop;
    logic          sel_valid;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic          hit1;
    logic          hit2;

    assign ld_ready = rst_ni && (count_q < DEPTH_C);

    always_comb begin
        push      = bus.ld_valid_i && ld_ready;
        // Pop only from entries already held, so a load is never bypassed.
        pop       = !bus.alu_valid_i && (count_q != '0);
        sel_valid = bus.alu_valid_i || pop;
        sel_rd    = bus.alu_valid_i ? bus.alu_rd_i   : buf_rd_q[rd_ptr_q];
        sel_data  = bus.alu_valid_i ? bus.alu_data_i : buf_data_q[rd_ptr_q];

        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

        // rd == 0 still consumes the slot but never raises the write enable.
        we_d      = sel_valid && (sel_rd != 5'd0);
        ws_d      = sel_valid ? sel_rd   : ws_q;
        wd_d      = sel_valid ? sel_data : wd_q;

        hit1         = we_q && (ws_q != 5'd0) && (ws_q == bus.rs1_i);
        hit2         = we_q && (ws_q != 5'd0) && (ws_q == bus.rs2_i);
        fwd1_valid_d = hit1;
        fwd2_valid_d = hit2;
        fwd1_data_d  = hit1 ? wd_q : fwd1_data_q;
        fwd2_data_d  = hit2 ? wd_q : fwd2_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_rd_q[wr_ptr_q]   <= bus.ld_rd_i;
            buf_data_q[wr_ptr_q] <= bus.ld_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            we_q         <= 1'b0;
            ws_q         <= '0;
            wd_q         <= '0;
            fwd1_valid_q <= 1'b0;
            fwd2_valid_q <= 1'b0;
            fwd1_data_q  <= '0;
            fwd2_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            we_q         <= we_d;
            ws_q         <= ws_d;
            wd_q         <= wd_d;
            fwd1_valid_q <= fwd1_valid_d;
            fwd2_valid_q <= fwd2_valid_d;
            fwd1_data_q  <= fwd1_data_d;
            fwd2_data_q  <= fwd2_data_d;
        end
    end

    assign bus.ld_ready_o   = ld_ready;
    assign bus.ld_count_o   = count_q;
    assign bus.we_o         = we_q;
    assign bus.ws_o         = ws_q;
    assign bus.wd_o         = wd_q;
    assign bus.fwd1_valid_o = fwd1_valid_q;
    assign bus.fwd2_valid_o = fwd2_valid_q;
    assign bus.fwd1_data_o  = fwd1_data_q;
    assign bus.fwd2_data_o  = fwd2_data_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes are queued as stimulus is
// issued and a negedge monitor pops and compares every register-file write.
module tb_reg_writeback;
    localparam int LD_DEPTH = 2;

    logic clk;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [36:0] exp_q[$];

    reg_writeback_if #(.LD_DEPTH(LD_DEPTH)) bus ();

    reg_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, %0d writes outstanding, required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid_i = 1'b0;
        bus.alu_rd_i    = '0;
        bus.alu_data_i  = '0;
        bus.ld_valid_i  = 1'b0;
        bus.ld_rd_i     = '0;
        bus.ld_data_i   = '0;
        bus.rs1_i       = '0;
        bus.rs2_i       = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = rd;
        bus.alu_data_i  = data;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data);
        bus.ld_valid_i = 1'b1;
        bus.ld_rd_i    = rd;
        bus.ld_data_i  = data;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_ni && bus.we_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got ws=%0d wd=0x%08h, expected no write", bus.ws_o, bus.wd_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.ws_o, bus.wd_o} !== e) begin
                    n_fail++;
                    $display("FAIL write_order: got ws=%0d wd=0x%08h, expected ws=%0d wd=0x%08h",
                             bus.ws_o, bus.wd_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();

        // Reset values
        #12;
        check("rst_we",       {31'd0, bus.we_o}, 32'd0);
        check("rst_ws",       {27'd0, bus.ws_o}, 32'd0);
        check("rst_wd",       bus.wd_o, 32'd0);
        check("rst_fwd1_v",   {31'd0, bus.fwd1_valid_o}, 32'd0);
        check("rst_fwd2_v",   {31'd0, bus.fwd2_valid_o}, 32'd0);
        check("rst_fwd1_d",   bus.fwd1_data_o, 32'd0);
        check("rst_fwd2_d",   bus.fwd2_data_o, 32'd0);
        check("rst_count",    32'(bus.ld_count_o), 32'd0);
        check("rst_ready",    {31'd0, bus.ld_ready_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        #1;
        check("release_ready", {31'd0, bus.ld_ready_o}, 32'd1);

        // ALU only
        drive_alu(5'd5, 32'hDEADBEEF);
        expect_write(5'd5, 32'hDEADBEEF);
        tick();
        idle_inputs();
        check("alu_we_n1", {31'd0, bus.we_o}, 32'd1);
        tick();
        check("alu_we_n2", {31'd0, bus.we_o}, 32'd0);
        drain("alu_drain");

        // ALU and load collide in one cycle
        drive_alu(5'd3, 32'h11);
        drive_ld(5'd4, 32'h22);
        expect_write(5'd3, 32'h11);
        expect_write(5'd4, 32'h22);
        tick();
        idle_inputs();
        check("col_count1", 32'(bus.ld_count_o), 32'd1);
        tick();
        check("col_count0", 32'(bus.ld_count_o), 32'd0);
        check("col_ws",     {27'd0, bus.ws_o}, 32'd4);
        tick();
        check("col_we_low", {31'd0, bus.we_o}, 32'd0);
        drain("col_drain");

        // Starvation fills the buffer; loads drain in push order afterwards
        expect_write(5'd10, 32'h100);
        expect_write(5'd11, 32'h101);
        expect_write(5'd12, 32'h102);
        expect_write(5'd13, 32'h103);
        expect_write(5'd20, 32'h200);
        expect_write(5'd21, 32'h201);
        expect_write(5'd22, 32'h202);
        drive_alu(5'd10, 32'h100);
        drive_ld(5'd20, 32'h200);
        tick();
        drive_alu(5'd11, 32'h101);
        drive_ld(5'd21, 32'h201);
        tick();
        drive_alu(5'd12, 32'h102);
        drive_ld(5'd22, 32'h202);
        check("full_ready",  {31'd0, bus.ld_ready_o}, 32'd0);
        check("full_count",  32'(bus.ld_count_o), 32'd2);
        tick();
        drive_alu(5'd13, 32'h103);
        check("full_hold",   {31'd0, bus.ld_ready_o}, 32'd0);
        tick();
        bus.alu_valid_i = 1'b0;
        check("full_noalu_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        tick();
        check("pop_ready",   {31'd0, bus.ld_ready_o}, 32'd1);
        check("pop_count",   32'(bus.ld_count_o), 32'd1);
        tick();
        idle_inputs();
        check("pushpop_count", 32'(bus.ld_count_o), 32'd1);
        tick();
        check("starve_empty", 32'(bus.ld_count_o), 32'd0);
        drain("starve_drain");

        // Load to r0 pops without a write
        drive_ld(5'd0, 32'hFF);
        tick();
        idle_inputs();
        check("rd0_count1", 32'(bus.ld_count_o), 32'd1);
        tick();
        check("rd0_count0", 32'(bus.ld_count_o), 32'd0);
        check("rd0_we",     {31'd0, bus.we_o}, 32'd0);
        tick();
        check("rd0_we_n2",  {31'd0, bus.we_o}, 32'd0);

        // Forwarding on a write-same-edge read
        drive_alu(5'd7, 32'h1234);
        expect_write(5'd7, 32'h1234);
        tick();
        idle_inputs();
        bus.rs1_i = 5'd7;
        bus.rs2_i = 5'd0;
        tick();
        check("fwd1_valid", {31'd0, bus.fwd1_valid_o}, 32'd1);
        check("fwd1_data",  bus.fwd1_data_o, 32'h1234);
        check("fwd2_valid", {31'd0, bus.fwd2_valid_o}, 32'd0);
        tick();
        check("fwd1_stale", {31'd0, bus.fwd1_valid_o}, 32'd0);
        bus.rs1_i = 5'd0;
        drive_alu(5'd9, 32'h55AA);
        expect_write(5'd9, 32'h55AA);
        tick();
        idle_inputs();
        bus.rs1_i = 5'd8;
        bus.rs2_i = 5'd9;
        tick();
        check("fwd2_only_v1", {31'd0, bus.fwd1_valid_o}, 32'd0);
        check("fwd2_only_v2", {31'd0, bus.fwd2_valid_o}, 32'd1);
        check("fwd2_only_d2", bus.fwd2_data_o, 32'h55AA);
        idle_inputs();
        drain("fwd_drain");

        // Reset mid-flight drops buffered loads and the in-flight write
        drive_alu(5'd9, 32'h9);
        drive_ld(5'd1, 32'h1);
        expect_write(5'd9, 32'h9);
        tick();
        drive_alu(5'd9, 32'hA);
        drive_ld(5'd2, 32'h2);
        expect_write(5'd9, 32'hA);
        tick();
        drive_alu(5'd9, 32'hB);
        bus.ld_valid_i = 1'b0;
        tick();
        check("mid_count2", 32'(bus.ld_count_o), 32'd2);
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_we",    {31'd0, bus.we_o}, 32'd0);
        check("mid_rst_wd",    bus.wd_o, 32'd0);
        check("mid_rst_count", 32'(bus.ld_count_o), 32'd0);
        check("mid_rst_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        #1;
        check("mid_rel_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("mid_rel_count", 32'(bus.ld_count_o), 32'd0);
        check("mid_rel_we",    {31'd0, bus.we_o}, 32'd0);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
